multichannel_stable_sampler: RTL
================================

MULTICHANNEL_STABLE_SAMPLER -- requirements
Module: multichannel_stable_sampler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the bits per channel.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent channels; legal range >= 1.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the synchroniser flip-flop depth per input bit; legal range >= 2.
REQ-004 Parameter STABLE_CYCLES, default 3, SHALL set the number of consecutive equal synchronised samples required before a commit; legal range >= 1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 a  input  CHANNELS*DATA_WIDTH  SHALL carry asynchronous source words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 hold  input  1  SHALL suppress commits on all channels while high.
REQ-009 b  output  CHANNELS*DATA_WIDTH  SHALL carry the committed words per channel, registered, with the same packing as a.
REQ-010 b_update  output  CHANNELS  SHALL be a one-cycle pulse per channel, high in the cycle after that channel's b changes or first commits.
REQ-011 b_valid  output  CHANNELS  SHALL be high per channel once that channel has committed at least once since reset.

Function
REQ-012 Each channel SHALL pass every bit of a through a SYNC_STAGES-deep flip-flop chain; s = last stage and p = s delayed one clock.
REQ-013 Each channel SHALL hold a counter cnt of width clog2(STABLE_CYCLES+1): on an edge with s != p, cnt <= 0; on an edge with s == p, cnt <= min(cnt+1, STABLE_CYCLES), saturating and never wrapping.
REQ-014 Commit condition at an edge SHALL be: !hold && s == p && cnt >= STABLE_CYCLES-1 && (!b_valid || s != b).
REQ-015 On commit: b <= s, b_valid <= 1, b_update <= 1; otherwise b and b_valid hold and b_update <= 0.
REQ-016 Latency: if a is first sampled with a new constant value at edge k, with hold low and no further change, b SHALL update at edge k+SYNC_STAGES+STABLE_CYCLES.
REQ-017 A change of s before cnt reaches the threshold SHALL restart qualification; no intermediate value SHALL ever appear on b.
REQ-018 With hold high, counters SHALL keep running and saturate; after hold falls, a pending commit SHALL occur at the first edge meeting REQ-014.
REQ-019 A stable value equal to the current b with b_valid high SHALL NOT produce b_update.
REQ-020 Channels SHALL be fully independent; simultaneous commits on several channels in one edge SHALL all take effect.
REQ-021 b_update SHALL never be high for two consecutive cycles on one channel without an intervening s change.

Reset
REQ-022 While rst is high at an edge: synchroniser stages, p, cnt, b, b_valid and b_update SHALL all become 0.
REQ-023 Reset asserted mid-qualification SHALL discard progress; after release, qualification SHALL restart from the zeroed synchroniser chain.
REQ-024 A constant a held through reset release SHALL commit (including a value of 0, via !b_valid) at edge r+SYNC_STAGES+STABLE_CYCLES, where r is the first edge with rst low.

Structure
REQ-025 Default parameter constants and a clog2 constant function SHALL reside in shared package bridge_pkg.
REQ-026 The per-channel logic SHALL be the sub-module stable_sampler_channel, instantiated CHANNELS times by a generate loop; the top level SHALL contain only packing and hold fan-out.

Verification
REQ-027 Defaults; after reset, a = 0x1111_2222_3333_4444 constant, first sampled at edge 10 -> all four b_update pulse after edge 15, b equals a, b_valid = 4'b1111.
REQ-028 Channel 0 toggles 0x00AA/0x0055 every 2 cycles for 20 cycles, then holds 0x00AA -> no b_update during toggling; a single commit of 0x00AA 5 edges after the final change.
REQ-029 hold high; channel 2 changes to 0xBEEF and stays; hold falls 10 cycles later -> b[2] = 0xBEEF exactly one edge after hold falls, one pulse.
REQ-030 rst asserted 2 cycles after channel 1 changes to 0x1234 -> all outputs 0 next edge; after release, commit of 0x1234 at r+5.
REQ-031 Rewrite the same stable value 0x4444 onto channel 3 after it has committed -> no b_update; channels 0 and 1 changed on the same edge -> both pulse on the same cycle.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared defaults and constant helpers for the stable-sampler bridge.
package bridge_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned DEF_CHANNELS      = 4;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/stable_sampler_channel.sv
// One channel: synchronise an async word, qualify it as stable, then commit it.
import bridge_pkg::*;

module stable_sampler_channel #(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  b_update,
    output logic                  b_valid
);

    localparam int unsigned CW  = clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] THR = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0]                 fill_q;
    logic [DATA_WIDTH-1:0]                  s;
    logic [DATA_WIDTH-1:0]                  p_q;
    logic                                   p_fill_q;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  b_q;
    logic                                   b_valid_q, b_update_q;
    logic                                   same, commit;

    assign s = sync_q[SYNC_STAGES-1];

    // fill_q tracks data that entered the chain after reset, so the zeroed
    // chain never qualifies as a stable 0 before real samples reach p.
    always_comb begin
        same   = fill_q[SYNC_STAGES-1] && p_fill_q && (s == p_q);
        cnt_d  = '0;
        if (same) begin
            cnt_d = (cnt_q >= SAT) ? SAT : cnt_q + ONE;
        end
        commit = !hold && same && (cnt_q >= THR) && (!b_valid_q || (s != b_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            fill_q     <= '0;
            p_q        <= '0;
            p_fill_q   <= 1'b0;
            cnt_q      <= '0;
            b_q        <= '0;
            b_valid_q  <= 1'b0;
            b_update_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], a};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            p_q        <= s;
            p_fill_q   <= fill_q[SYNC_STAGES-1];
            cnt_q      <= cnt_d;
            b_update_q <= commit;
            if (commit) begin
                b_q       <= s;
                b_valid_q <= 1'b1;
            end
        end
    end

    assign b        = b_q;
    assign b_update = b_update_q;
    assign b_valid  = b_valid_q;

endmodule

// File: rtl/multichannel_stable_sampler.sv
// Packs CHANNELS independent stable samplers onto flat buses with a shared hold.
import bridge_pkg::*;

module multichannel_stable_sampler #(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] a,
    input  logic                           hold,
    output logic [CHANNELS*DATA_WIDTH-1:0] b,
    output logic [CHANNELS-1:0]            b_update,
    output logic [CHANNELS-1:0]            b_valid
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        stable_sampler_channel #(
            .DATA_WIDTH   (DATA_WIDTH),
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .a       (a[g*DATA_WIDTH +: DATA_WIDTH]),
            .hold    (hold),
            .b       (b[g*DATA_WIDTH +: DATA_WIDTH]),
            .b_update(b_update[g]),
            .b_valid (b_valid[g])
        );
    end

endmodule
